seq_sm_mul: RTL and testbench

SEQ_SM_MUL -- requirements
Module: seq_sm_mul

---
 rtl/seq_sm_mul.sv | 133 +++++++++++++
 tb/tb_seq_sm_mul.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/seq_sm_mul.sv
// ---------------------------------------------------------------------------
// seq_sm_mul -- sequential sign-magnitude multiplier (shift-and-add)
//
// Multiplies two sign-magnitude operands one multiplier bit per clock.
// Magnitude is the exact unsigned product. The sign is the XOR of the
// operand signs, except that a zero product is always reported as +0.
//
// Parameters
//   MAG_W         magnitude width of each operand (2..16)
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   start         begin a multiply (sampled only while idle)
//   a, b          operands: bit MAG_W = sign, bits MAG_W-1:0 = magnitude
//   busy          high while calculating or presenting the result
//   done          one-cycle pulse; result and flags are valid from this cycle
//   result        product: bit 2*MAG_W = sign, bits 2*MAG_W-1:0 = magnitude
//   zeroFlag      product magnitude is zero
//   negativeFlag  product is strictly negative (equals result sign)
//
// Build option
//   SEQ_SM_MUL_EARLY_ZERO_EN  when defined, a zero operand magnitude skips
//                             the shift-and-add loop and goes straight to
//                             DONE. The outputs are identical either way.
// ---------------------------------------------------------------------------
module seq_sm_mul #(
    parameter int MAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [MAG_W:0]     a,
    input  logic [MAG_W:0]     b,
    output logic               busy,
    output logic               done,
    output logic [2*MAG_W:0]   result,
    output logic               zeroFlag,
    output logic               negativeFlag
);

    localparam int CNT_W = $clog2(MAG_W + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state;
    logic [CNT_W-1:0]     count;
    logic [2*MAG_W-1:0]   acc;
    logic [2*MAG_W-1:0]   mcand;     // multiplicand, shifted left once per step
    logic [MAG_W-1:0]     mplier;    // multiplier, shifted right once per step
    logic                 sign;

    logic [2*MAG_W-1:0]   addend;
    logic [2*MAG_W-1:0]   acc_next;

    // The current multiplier bit always sits in mplier[0] and mcand already
    // carries the matching shift, so each step is a single conditional add.
    always_comb begin
        addend   = mplier[0] ? mcand : '0;
        acc_next = acc + addend;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            count        <= '0;
            acc          <= '0;
            mcand        <= '0;
            mplier       <= '0;
            sign         <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result       <= '0;
            zeroFlag     <= 1'b1;
            negativeFlag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand  <= {{MAG_W{1'b0}}, a[MAG_W-1:0]};
                        mplier <= b[MAG_W-1:0];
                        sign   <= a[MAG_W] ^ b[MAG_W];
                        acc    <= '0;
                        count  <= CNT_W'(MAG_W);
                        busy   <= 1'b1;
`ifdef SEQ_SM_MUL_EARLY_ZERO_EN
                        if (a[MAG_W-1:0] == '0 || b[MAG_W-1:0] == '0) begin
                            result       <= '0;
                            zeroFlag     <= 1'b1;
                            negativeFlag <= 1'b0;
                            done         <= 1'b1;
                            state        <= DONE;
                        end else begin
                            state <= CALC;
                        end
`else
                        state <= CALC;
`endif
                    end
                end

                CALC: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count - CNT_W'(1);
                    // Last iteration: publish the sum that includes this step.
                    if (count == CNT_W'(1)) begin
                        result       <= {sign && (acc_next != '0), acc_next};
                        zeroFlag     <= (acc_next == '0);
                        negativeFlag <= sign && (acc_next != '0);
                        done         <= 1'b1;
                        state        <= DONE;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_sm_mul.sv
module tb_seq_sm_mul;
    localparam int MAG_W = 4;
    localparam int RW    = 2 * MAG_W + 1;

`ifdef SEQ_SM_MUL_EARLY_ZERO_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [MAG_W:0]  a = '0;
    logic [MAG_W:0]  b = '0;
    logic            busy, done, zeroFlag, negativeFlag;
    logic [RW-1:0]   result;

    int n_tests = 0;
    int n_fail  = 0;

    seq_sm_mul #(.MAG_W(MAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .result(result),
        .zeroFlag(zeroFlag), .negativeFlag(negativeFlag)
    );

    always #5 clk = ~clk;

    // Behavioural model: remaining busy cycles plus the published outputs.
    int            m_left = 0;
    logic [RW-1:0] m_res  = '0;
    logic          m_z    = 1'b1;
    logic          m_n    = 1'b0;
    logic [RW-1:0] p_res;
    logic          p_z, p_n;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0;
            m_res  = '0;
            m_z    = 1'b1;
            m_n    = 1'b0;
        end else begin
            if (m_left == 0) begin
                if (start) begin
                    int unsigned ma, mb, prod;
                    logic s;
                    ma   = a[MAG_W-1:0];
                    mb   = b[MAG_W-1:0];
                    prod = ma * mb;
                    s    = (a[MAG_W] != b[MAG_W]) && (prod != 0);
                    p_res = {s, (2*MAG_W)'(prod)};
                    p_z   = (prod == 0);
                    p_n   = s;
                    m_left = (EARLY && (ma == 0 || mb == 0)) ? 1 : MAG_W + 1;
                end
            end else begin
                m_left = m_left - 1;
            end
            if (m_left == 1) begin
                m_res = p_res;
                m_z   = p_z;
                m_n   = p_n;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        logic [RW+3:0] act_v, exp_v;
        act_v = {busy, done, result, zeroFlag, negativeFlag};
        exp_v = {(m_left != 0), (m_left == 1), m_res, m_z, m_n};
        check("cycle {busy,done,result,z,n}", 32'(act_v), 32'(exp_v));
    end

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (busy) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Start one op, count cycles after the accepting edge until done,
    // optionally poking start/operands during the calculation.
    task automatic run_op(input logic [MAG_W:0] ta, input logic [MAG_W:0] tb_v,
                          input logic [RW-1:0] exp_r, input int exp_k,
                          input bit poke, input string nm);
        int k = 0;
        int pulses = 0;
        wait_idle();
        @(posedge clk); #1;
        a = ta; b = tb_v; start = 1'b1;
        @(posedge clk); #1;              // accepting edge E
        start = 1'b0;
        while (pulses == 0 && k < 30) begin
            @(negedge clk);
            k++;
            if (done) pulses++;
            if (poke && pulses == 0) begin
                #1 start = 1'b1; a = $urandom; b = $urandom;
            end
        end
        start = 1'b0;
        check({nm, "_latency"}, 32'(k), 32'(exp_k));
        check({nm, "_result"}, 32'(result), 32'(exp_r));
        // no further done pulse for a while
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check({nm, "_pulses"}, 32'(pulses), 32'd1);
    endtask

    initial begin
        int zl;
        zl = EARLY ? 1 : MAG_W + 1;

        #12;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_result", 32'(result), 32'd0);
        check("reset_zero", 32'(zeroFlag), 32'd1);
        @(negedge clk); #1 rst_n = 1'b1;

        // Start on the first edge after reset release.
        run_op(5'b0_0011, 5'b1_0101, 9'b1_0000_1111, MAG_W + 1, 1'b0, "p3xm5");
        check("p3xm5_neg", 32'(negativeFlag), 32'd1);
        check("p3xm5_zero", 32'(zeroFlag), 32'd0);
        run_op(5'b0_1111, 5'b1_1111, 9'b1_1110_0001, MAG_W + 1, 1'b0, "p15xm15");
        run_op(5'b1_1111, 5'b1_1111, 9'b0_1110_0001, MAG_W + 1, 1'b0, "m15xm15");
        run_op(5'b1_0000, 5'b0_0111, 9'b0, zl, 1'b0, "m0xp7");
        check("m0xp7_zero", 32'(zeroFlag), 32'd1);
        check("m0xp7_neg", 32'(negativeFlag), 32'd0);
        run_op(5'b1_0110, 5'b0_0000, 9'b0, zl, 1'b0, "m6xp0");
        run_op(5'b0_0101, 5'b0_0110, 9'b0_0001_1110, MAG_W + 1, 1'b1, "poke5x6");

        // Held outputs through idle.
        repeat (3) @(negedge clk);
        check("hold_result", 32'(result), 32'b0_0001_1110);

        // Reset two cycles into CALC.
        wait_idle();
        @(posedge clk); #1 a = 5'b0_1001; b = 5'b0_0111; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_zero", 32'(zeroFlag), 32'd1);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'd0);
        end
        run_op(5'b0_0010, 5'b0_0011, 9'b0_0000_0110, MAG_W + 1, 1'b0, "p2xp3");

        // Random traffic, checked every cycle by the model compare.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            start = ($urandom_range(0, 2) == 0);
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 5) == 0) a[MAG_W-1:0] = '0;
            if ($urandom_range(0, 5) == 0) b[MAG_W-1:0] = '0;
            if (i == 200) begin
                rst_n = 1'b0;
                @(negedge clk); #1 rst_n = 1'b1;
            end
        end
        start = 1'b0;
        repeat (10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
